// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its boot loader.
// Holds the loader state encoding and the frame geometry constants.
package riscv_pkg;

  // Loader states: two header bytes, payload words, trailing checksum,
  // then either a running core or a sticky failure.
  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_t;

  // Bytes in the little-endian length header.
  localparam int BOOT_LEN_BYTES = 2;

  // Bytes packed into one instruction word.
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four stream bytes, LSB first, into a 32-bit word.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   clear      - synchronous clear of byte phase and partial word
//   shift_en   - accept data_in this cycle
//   data_in    - stream byte
//   word       - assembled word, valid while word_ready is high
//   word_ready - high in the cycle the final byte of a word is shifted in
module byte_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  phase;
  // Only the three earlier bytes need storing; the fourth is taken straight
  // from data_in so the word is complete in the same cycle as its last byte.
  logic [23:0] history;

  // Byte phase and partial-word history advance on every accepted byte.
  // The phase wraps 3 -> 0 naturally, starting the next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= 2'd0;
      history <= 24'd0;
    end else if (clear) begin
      phase   <= 2'd0;
      history <= 24'd0;
    end else if (shift_en) begin
      phase   <= phase + 2'd1;
      history <= {data_in, history[23:8]};
    end
  end

  assign word       = {data_in, history};
  assign word_ready = shift_en && (phase == LAST_PHASE);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (16-bit word count, payload
// words LSB first, XOR checksum), writes the words sequentially into IMEM and
// holds the core in reset until the checksum has been verified.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   in_valid   - in_byte is valid
//   in_byte    - stream byte
//   in_ready   - loader accepts a byte this cycle
//   reload     - start a new load (honoured only in RUN or ERR)
//   imem_we    - IMEM write strobe, one cycle per word
//   imem_waddr - IMEM word address
//   imem_wdata - instruction word
//   core_rst   - active-high hold for PC, register file and DMEM
//   done       - load verified, core running
//   err        - load failed (length or checksum), sticky until reload
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int         HDR_BITS = 8 * BOOT_LEN_BYTES;
  localparam logic [HDR_BITS:0] MAX_LEN = (HDR_BITS + 1)'(MAX_WORDS);

  boot_state_t         state;
  logic [7:0]          len_lo;
  logic [7:0]          csum;
  // One bit wider than the address so a full-size frame ends at MAX_WORDS
  // instead of wrapping to zero.
  logic [ADDR_W:0]     word_cnt;
  logic [ADDR_W:0]     n_words;

  logic                xfer;
  logic                restart;
  logic                pk_shift;
  logic                pk_ready;
  logic [31:0]         pk_word;
  logic [HDR_BITS-1:0] hdr_len;
  logic [ADDR_W:0]     cnt_next;

  assign xfer     = in_valid && in_ready;
  assign restart  = reload && ((state == ST_RUN) || (state == ST_ERR));
  assign pk_shift = xfer && (state == ST_DATA);
  assign hdr_len  = {in_byte, len_lo};
  assign cnt_next = word_cnt + {{ADDR_W{1'b0}}, 1'b1};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .shift_en   (pk_shift),
    .data_in    (in_byte),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  // Loader FSM. All outputs are registered and change together with the
  // state, so in_ready/core_rst/done/err always describe the current state.
  // The write strobe defaults low so it lasts exactly one cycle per word,
  // while address and data hold their last values between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_HDR0;
      in_ready   <= 1'b1;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
      word_cnt   <= '0;
      n_words    <= '0;
      csum       <= 8'd0;
      len_lo     <= 8'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_HDR0: begin
          if (xfer) begin
            len_lo <= in_byte;
            state  <= ST_HDR1;
          end
        end

        // A length that fits MAX_WORDS also fits ADDR_W+1 bits, so the
        // truncated copy in n_words is exact whenever DATA is entered.
        ST_HDR1: begin
          if (xfer) begin
            if ({1'b0, hdr_len} > MAX_LEN) begin
              state    <= ST_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else if (hdr_len == '0) begin
              state <= ST_CSUM;
            end else begin
              n_words <= hdr_len[ADDR_W:0];
              state   <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ in_byte;
            if (pk_ready) begin
              imem_we    <= 1'b1;
              imem_waddr <= word_cnt[ADDR_W-1:0];
              imem_wdata <= pk_word;
              word_cnt   <= cnt_next;
              if (cnt_next == n_words) begin
                state <= ST_CSUM;
              end
            end
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_byte == csum) begin
              state    <= ST_RUN;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end

        // IMEM is not cleared on reload; a shorter program leaves the
        // tail of the previous one in place.
        ST_RUN, ST_ERR: begin
          if (restart) begin
            state    <= ST_HDR0;
            in_ready <= 1'b1;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            csum     <= 8'd0;
          end
        end

        default: begin
          state    <= ST_ERR;
          err      <= 1'b1;
          done     <= 1'b0;
          core_rst <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: table of fixed frames with expected
// outcomes, randomized frames judged by a frame-level reference model, and
// hand-written sequences for mid-load reset and reload corner cases.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
  localparam int GUARD     = 32;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'd0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  bit          loaded = 1'b0;
  wr_t         wr_q[$];
  logic [31:0] frame_words[$];
  logic [31:0] mem[DEPTH];
  logic [31:0] exp_mem[DEPTH];

  // The bench plays the role of IMEM: it captures every write strobe.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_q.push_back('{addr: imem_waddr, data: imem_wdata});
      mem[imem_waddr] = imem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame-level reference: the outcome follows only from the length limit
  // and the XOR of the payload bytes against the byte actually sent.
  task automatic modelFrame(input int n, input bit use_csum, input logic [7:0] csum_val,
                            output bit exp_done, output bit exp_err, output int exp_writes);
    logic [7:0]  x;
    logic [31:0] w;
    bit          ok;
    if (n > MAX_WORDS) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_writes = 0;
    end else begin
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
        w = frame_words[i];
        x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      ok = !use_csum || (csum_val == x);
      exp_done = ok; exp_err = !ok; exp_writes = n;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic sendByte(input logic [7:0] b, input int gap_max, input bit noise);
    int gap;
    int guard;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      reload   = noise && ($urandom_range(3, 0) == 0);
      @(negedge clk);
    end
    reload   = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    checkOutput("in_ready before byte", in_ready, 1);
    guard = 0;
    while (!in_ready && guard < GUARD) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload in_ready", in_ready, 1);
    checkOutput("reload done", done, 0);
    checkOutput("reload err", err, 0);
    checkOutput("reload core_rst", core_rst, 1);
    loaded = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input bit use_csum, input logic [7:0] csum_val,
                               input int gap_max, input bit noise, input string tag);
    logic [15:0] nl;
    logic [31:0] w;
    logic [7:0]  x;
    wr_q.delete();
    nl = n[15:0];
    sendByte(nl[7:0], gap_max, noise);
    sendByte(nl[15:8], gap_max, noise);
    if (n > MAX_WORDS) begin
      checkOutput({tag, " err after LEN_HI"}, err, 1);
      checkOutput({tag, " in_ready after LEN_HI"}, in_ready, 0);
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checkOutput({tag, " err sticky"}, err, 1);
    end else begin
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
        w = frame_words[i];
        for (int k = 0; k < 4; k++) begin
          x = x ^ w[8*k +: 8];
          sendByte(w[8*k +: 8], gap_max, noise);
        end
      end
      sendByte(use_csum ? csum_val : x, gap_max, noise);
    end
  endtask

  // Entered on the falling edge right after the last handshake of a frame.
  task automatic checkResult(input string tag, input bit exp_done, input bit exp_err,
                             input int exp_writes);
    int mism;
    wr_t e;
    checkOutput({tag, " done"}, done, exp_done);
    checkOutput({tag, " err"}, err, exp_err);
    checkOutput({tag, " core_rst"}, core_rst, !exp_done);
    checkOutput({tag, " in_ready"}, in_ready, 0);
    repeat (2) @(negedge clk);
    checkOutput({tag, " write count"}, wr_q.size(), exp_writes);
    for (int i = 0; i < exp_writes && i < wr_q.size(); i++) begin
      e = wr_q[i];
      checkOutput({tag, " waddr"}, 32'(e.addr), i);
      checkOutput({tag, " wdata"}, e.data, frame_words[i]);
    end
    for (int i = 0; i < exp_writes; i++) exp_mem[i] = frame_words[i];
    mism = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_mem[a]) mism++;
    checkOutput({tag, " imem image mismatches"}, mism, 0);
    checkOutput({tag, " imem_we idle"}, imem_we, 0);
    loaded = 1'b1;
  endtask

  initial begin
    vec_t tbl[7];
    bit   m_done;
    bit   m_err;
    int   m_writes;
    int   n;
    bit   use_csum;
    logic [7:0] cv;
    wr_t  e;

    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = 32'd0;
      exp_mem[a] = 32'd0;
    end

    tbl[0] = '{"n2_good",  2,     32'h00500093, 32'h00A00113, 8'h71, 1'b1, 1'b0, 2};
    tbl[1] = '{"n2_bad",   2,     32'h00500093, 32'h00A00113, 8'h00, 1'b0, 1'b1, 2};
    tbl[2] = '{"n0_good",  0,     32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 0};
    tbl[3] = '{"n0_bad",   0,     32'h0,        32'h0,        8'h5A, 1'b0, 1'b1, 0};
    tbl[4] = '{"n1_good",  1,     32'hDEADBEEF, 32'h0,        8'h22, 1'b1, 1'b0, 1};
    tbl[5] = '{"n257",     257,   32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};
    tbl[6] = '{"n65535",   65535, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};

    // Reset state with no traffic.
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset core_rst", core_rst, 1);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset imem_we", imem_we, 0);
    checkOutput("reset imem_waddr", 32'(imem_waddr), 0);
    checkOutput("reset imem_wdata", imem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Fixed frames at full rate.
    for (int i = 0; i < 7; i++) begin
      if (loaded) doReload();
      frame_words.delete();
      frame_words.push_back(tbl[i].w0);
      frame_words.push_back(tbl[i].w1);
      applyStimulus(tbl[i].n, 1'b1, tbl[i].csum, 0, 1'b0, tbl[i].name);
      checkResult(tbl[i].name, tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_writes);
    end

    // Random short frames with gaps and stray reload pulses mid-load.
    for (int f = 0; f < 8; f++) begin
      if (loaded) doReload();
      n = int'($urandom_range(6, 1));
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
      use_csum = ($urandom_range(2, 0) == 0);
      cv = 8'($urandom);
      modelFrame(n, use_csum, cv, m_done, m_err, m_writes);
      applyStimulus(n, use_csum, cv, 3, 1'b1, "rand");
      checkResult("rand", m_done, m_err, m_writes);
    end

    // Largest frame with random stalls.
    if (loaded) doReload();
    frame_words.delete();
    for (int i = 0; i < MAX_WORDS; i++) frame_words.push_back($urandom);
    modelFrame(MAX_WORDS, 1'b0, 8'd0, m_done, m_err, m_writes);
    applyStimulus(MAX_WORDS, 1'b0, 8'd0, 2, 1'b1, "n256");
    checkResult("n256", m_done, m_err, m_writes);
    if (wr_q.size() > 0) begin
      e = wr_q[wr_q.size() - 1];
      checkOutput("n256 last waddr", 32'(e.addr), MAX_WORDS - 1);
    end

    // Reset after the sixth byte of a frame: first word stays, rest dropped.
    doReload();
    wr_q.delete();
    frame_words.delete();
    frame_words.push_back(32'h11223344);
    sendByte(8'd2, 0, 1'b0);
    sendByte(8'd0, 0, 1'b0);
    sendByte(8'h44, 0, 1'b0);
    sendByte(8'h33, 0, 1'b0);
    sendByte(8'h22, 0, 1'b0);
    sendByte(8'h11, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset in_ready", in_ready, 1);
    checkOutput("midreset core_rst", core_rst, 1);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset imem_we", imem_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midreset write count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      e = wr_q[0];
      checkOutput("midreset waddr", 32'(e.addr), 0);
      checkOutput("midreset wdata", e.data, 32'h11223344);
    end
    exp_mem[0] = 32'h11223344;
    loaded = 1'b0;
    frame_words.delete();
    frame_words.push_back(32'hCAFEF00D);
    frame_words.push_back(32'h0badc0de);
    modelFrame(2, 1'b0, 8'd0, m_done, m_err, m_writes);
    applyStimulus(2, 1'b0, 8'd0, 0, 1'b0, "after_reset");
    checkResult("after_reset", m_done, m_err, m_writes);

    // Reload together with a valid byte while running: byte must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'h03;
    reload   = 1'b1;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    checkOutput("coincide in_ready", in_ready, 1);
    checkOutput("coincide done", done, 0);
    checkOutput("coincide core_rst", core_rst, 1);
    loaded = 1'b0;
    frame_words.delete();
    frame_words.push_back(32'h12345678);
    modelFrame(1, 1'b0, 8'd0, m_done, m_err, m_writes);
    applyStimulus(1, 1'b0, 8'd0, 0, 1'b0, "coincide");
    checkResult("coincide", m_done, m_err, m_writes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
